// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
//   Shared definitions for the multiply/divide unit and for the Controller,
//   which decodes mult/div/mfhi/mflo/mthi/mtlo using the same operation codes.
//
//   Contents:
//     MD_NONE..MD_MTLO  3-bit MDop operation codes
//     md_state_t        unit state encoding (MD_IDLE / MD_BUSY)
//     md_is_arith()     op launches a multicycle multiply/divide
//     md_is_div()       op is a divide (DIV or DIVU)
// ---------------------------------------------------------------------------
package md_pkg;

  localparam int MD_OP_W = 3;
  localparam int MD_DATA_W = 32;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  function automatic logic md_is_arith(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Multicycle multiply/divide unit holding the architectural HI/LO
//   registers. The full result is computed at launch and parked in
//   hi_pend/lo_pend; HI/LO only change when the fixed latency expires, so
//   the pipeline sees the usual multicycle timing while the arithmetic itself
//   is a single combinational step.
//
//   Parameters:
//     MULT_CYCLES  cycles busy stays high for mult/multu (>=1)
//     DIV_CYCLES   cycles busy stays high for div/divu   (>=1)
//
//   Ports:
//     clk    in   pipeline clock
//     reset  in   synchronous, active-high; clears all state
//     start  in   one-cycle launch pulse from EX
//     MDop   in   operation code (md_pkg::MD_*)
//     A      in   rs operand (forwarded)
//     B      in   rt operand (forwarded)
//     busy   out  operation in flight (registered)
//     HI     out  HI register
//     LO     out  LO register
// ---------------------------------------------------------------------------
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MD_OP_W-1:0]   MDop,
  input  logic [MD_DATA_W-1:0] A,
  input  logic [MD_DATA_W-1:0] B,
  output logic                 busy,
  output logic [MD_DATA_W-1:0] HI,
  output logic [MD_DATA_W-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Signed divide returning {remainder, quotient}. The -2^31 / -1 case is
  // resolved explicitly: negating -2^31 wraps back to 0x80000000 with a zero
  // remainder, instead of relying on the simulator's overflow behaviour.
  // A zero divisor returns 0; the caller never commits that result.
  function automatic logic [2*MD_DATA_W-1:0] div_signed(
    input logic signed [MD_DATA_W-1:0] n,
    input logic signed [MD_DATA_W-1:0] d
  );
    logic signed [MD_DATA_W-1:0] q;
    logic signed [MD_DATA_W-1:0] r;
    if (d == '0) begin
      q = '0;
      r = '0;
    end else if (d == -1) begin
      q = -n;
      r = '0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  function automatic logic [2*MD_DATA_W-1:0] div_unsigned(
    input logic [MD_DATA_W-1:0] n,
    input logic [MD_DATA_W-1:0] d
  );
    logic [MD_DATA_W-1:0] q;
    logic [MD_DATA_W-1:0] r;
    if (d == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  md_state_t               state;
  md_state_t               state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;

  logic                    idle_start;
  logic                    launch;
  logic                    finish;

  logic signed [MD_DATA_W-1:0]   a_s;
  logic signed [MD_DATA_W-1:0]   b_s;
  logic signed [2*MD_DATA_W-1:0] prod_s;
  logic [2*MD_DATA_W-1:0]        prod_u;
  logic [2*MD_DATA_W-1:0]        result;
  logic                          result_ok;

  logic [MD_DATA_W-1:0]    hi_pend;
  logic [MD_DATA_W-1:0]    lo_pend;
  logic                    pend_ok;

  assign idle_start = (state == MD_IDLE) && start;
  assign launch     = idle_start && md_is_arith(MDop);
  assign finish     = (state == MD_BUSY) && (cnt == CNT_ONE);
  assign busy       = (state == MD_BUSY);

  assign a_s    = $signed(A);
  assign b_s    = $signed(B);
  assign prod_s = a_s * b_s;
  assign prod_u = {{MD_DATA_W{1'b0}}, A} * {{MD_DATA_W{1'b0}}, B};

  always_comb begin
    result    = '0;
    result_ok = 1'b1;
    case (MDop)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = div_signed(a_s, b_s);
      MD_DIVU:  result = div_unsigned(A, B);
      default:  result = '0;
    endcase
    // A zero divisor still occupies the unit for the full divide latency,
    // but the architectural registers must not be disturbed.
    if (md_is_div(MDop) && (B == '0)) begin
      result_ok = 1'b0;
    end
  end

  // State and latency counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MD_IDLE: begin
        if (launch) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = md_is_div(MDop) ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt == CNT_ONE) begin
          state_nxt = MD_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pending result capture and HI/LO commit
  always_ff @(posedge clk) begin
    if (reset) begin
      HI      <= '0;
      LO      <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
      pend_ok <= 1'b0;
    end else begin
      if (launch) begin
        hi_pend <= result[2*MD_DATA_W-1:MD_DATA_W];
        lo_pend <= result[MD_DATA_W-1:0];
        pend_ok <= result_ok;
      end
      if (finish && pend_ok) begin
        HI <= hi_pend;
        LO <= lo_pend;
      end
      if (idle_start && (MDop == MD_MTHI)) begin
        HI <= A;
      end
      if (idle_start && (MDop == MD_MTLO)) begin
        LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .MDop (MDop),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Counts negedges with busy high; flags any HI/LO movement while busy.
  task automatic wait_idle(input logic [31:0] ph, input logic [31:0] pl,
                           output int n, output logic moved);
    n = 0;
    moved = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (HI !== ph || LO !== pl) moved = 1'b1;
      @(negedge clk);
    end
  endtask

  // Called on a negedge; launches one op and checks latency and results.
  task automatic run_op(input string tag, input vec_t v);
    logic [31:0] ph;
    logic [31:0] pl;
    int          n;
    logic        moved;
    ph = HI;
    pl = LO;
    start = 1'b1;
    MDop  = v.op;
    A     = v.a;
    B     = v.b;
    @(negedge clk);
    start = 1'b0;
    MDop  = 3'($urandom_range(0, 7));
    A     = $urandom;
    B     = $urandom;
    wait_idle(ph, pl, n, moved);
    check({tag, "_cycles"}, n, v.cyc);
    if (v.cyc != 0) check({tag, "_hold"}, {31'b0, moved}, 32'd0);
    check({tag, "_hi"}, HI, v.hi);
    check({tag, "_lo"}, LO, v.lo);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic moved;

    tbl[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    tbl[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    tbl[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[3]  = '{MD_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    tbl[4]  = '{MD_MTHI,  32'h00000011, 32'd0,        32'h00000011, 32'h00000003, 0};
    tbl[5]  = '{MD_MTLO,  32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
    tbl[6]  = '{MD_DIV,   32'd5,        32'd0,        32'h00000011, 32'h00000022, 10};
    tbl[7]  = '{MD_DIVU,  32'hFFFFFFFF, 32'd0,        32'h00000011, 32'h00000022, 10};
    tbl[8]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    tbl[9]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    tbl[10] = '{MD_MULT,  32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFF9, 5};
    tbl[11] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    tbl[12] = '{MD_DIVU,  32'h80000000, 32'd3,        32'h00000002, 32'h2AAAAAAA, 10};
    tbl[13] = '{MD_MTHI,  32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'h2AAAAAAA, 0};
    tbl[14] = '{MD_NONE,  32'h00000123, 32'd9,        32'hDEADBEEF, 32'h2AAAAAAA, 0};
    tbl[15] = '{3'd7,     32'h00000456, 32'd9,        32'hDEADBEEF, 32'h2AAAAAAA, 0};
    tbl[16] = '{MD_MULTU, 32'd0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000, 5};

    reset = 1'b1;
    start = 1'b0;
    MDop  = MD_NONE;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("v%0d", i), tbl[i]);
    end

    // MTHI, then a MULT with start re-pulsed (MTLO, then DIV) while busy.
    run_op("mthi", '{MD_MTHI, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'h00000000, 0});
    start = 1'b1;
    MDop  = MD_MULT;
    A     = 32'd2;
    B     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    A     = 32'h0;
    @(negedge clk);
    check("ign_busy2", {31'b0, busy}, 32'd1);
    start = 1'b1;
    MDop  = MD_MTLO;
    A     = 32'h00000055;
    @(negedge clk);
    check("ign_lo_mtlo", LO, 32'd0);
    MDop  = MD_DIV;
    A     = 32'd100;
    B     = 32'd1;
    @(negedge clk);
    start = 1'b0;
    MDop  = MD_NONE;
    wait_idle(32'hDEADBEEF, 32'd0, n, moved);
    check("ign_cycles", 3 + n, 5);
    check("ign_hold", {31'b0, moved}, 32'd0);
    check("ign_hi", HI, 32'd0);
    check("ign_lo", LO, 32'd6);
    @(negedge clk);
    check("ign_no_relaunch", {31'b0, busy}, 32'd0);

    // Reset during the third busy cycle of a DIV.
    start = 1'b1;
    MDop  = MD_DIV;
    A     = 32'd100;
    B     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    run_op("post_rst", '{MD_MULTU, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
